// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one pipelined fp_add between NUM_REQ requesters.
// Round-robin issue, requester-ID tag pipe matched to the adder latency,
// and a credit-protected result FIFO feeding a registered response stream.
module fp_add_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ADD_LATENCY  = 3,
    parameter int RESULT_DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*32-1:0]      req_a_i,
    input  logic [NUM_REQ*32-1:0]      req_b_i,
    output logic                       add_valid_o,
    output logic [31:0]                add_a_o,
    output logic [31:0]                add_b_o,
    input  logic                       add_valid_i,
    input  logic [31:0]                add_result_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [$clog2(NUM_REQ)-1:0] res_id_o,
    output logic [31:0]                res_data_o,
    output logic                       err_o
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int CW      = $clog2(RESULT_DEPTH + 1);
    localparam int PW      = $clog2(RESULT_DEPTH);
    localparam int IGN_W   = $clog2(ADD_LATENCY + 1);
    localparam int ENTRY_W = ID_W + 32;

    // Operand unpacking
    logic [31:0] op_a [NUM_REQ];
    logic [31:0] op_b [NUM_REQ];

    // Arbitration state
    logic [ID_W-1:0] last_grant_q;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;
    logic            grant_found;
    logic            issue;

    // Credits: in-flight adds plus results held in the FIFO
    logic [CW-1:0] credit_q;
    logic [CW-1:0] credit_d;

    // Tag pipe
    logic [ADD_LATENCY-1:0] tag_valid_q;
    logic [ID_W-1:0]        tag_id_q [ADD_LATENCY];
    logic                   tag_out_valid;
    logic [ID_W-1:0]        tag_out_id;

    // Post-reset window in which stale adder outputs are dropped
    logic [IGN_W-1:0] ignore_q;
    logic             ignore_active;

    // Result FIFO (count includes the entry currently on the response port)
    logic [ENTRY_W-1:0] fifo_mem [RESULT_DEPTH];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [PW-1:0]      rd_ptr_d;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic [CW-1:0]      remain;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] push_entry;
    logic               head_valid_d;
    logic [ENTRY_W-1:0] head_entry_d;

    // Registered response port and error flag
    logic            res_valid_q;
    logic [ID_W-1:0] res_id_q;
    logic [31:0]     res_data_q;
    logic            err_q;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign op_a[gi]        = req_a_i[gi*32 +: 32];
        assign op_b[gi]        = req_b_i[gi*32 +: 32];
        assign req_ready_o[gi] = issue && (grant_idx == ID_W'(gi));
    end

    // Round-robin search: first valid requester after the last grantee
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(last_grant_q) + 1 + i) % NUM_REQ);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign issue       = !rst_i && grant_found && (credit_q < CW'(RESULT_DEPTH));
    assign add_valid_o = issue;
    assign add_a_o     = issue ? op_a[grant_idx] : 32'd0;
    assign add_b_o     = issue ? op_b[grant_idx] : 32'd0;

    assign tag_out_valid = tag_valid_q[ADD_LATENCY-1];
    assign tag_out_id    = tag_id_q[ADD_LATENCY-1];
    assign ignore_active = (ignore_q != '0);

    assign push       = tag_out_valid && add_valid_i && !ignore_active;
    assign pop        = res_valid_q && res_ready_i;
    assign push_entry = {tag_out_id, add_result_i};

    assign credit_d = credit_q + CW'(issue) - CW'(pop);
    assign count_d  = count_q + CW'(push) - CW'(pop);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);
    assign remain   = count_q - CW'(pop);

    // Next head of the FIFO; a push into an otherwise empty FIFO bypasses memory
    always_comb begin
        head_valid_d = 1'b0;
        head_entry_d = '0;
        if (remain != '0) begin
            head_valid_d = 1'b1;
            head_entry_d = fifo_mem[rd_ptr_d];
        end else if (push) begin
            head_valid_d = 1'b1;
            head_entry_d = push_entry;
        end
    end

    // Arbitration pointer, credits, ignore window and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            credit_q     <= '0;
            ignore_q     <= IGN_W'(ADD_LATENCY);
            err_q        <= 1'b0;
        end else begin
            if (issue) begin
                last_grant_q <= grant_idx;
            end
            credit_q <= credit_d;
            if (ignore_active) begin
                ignore_q <= ignore_q - IGN_W'(1);
            end
            if (!ignore_active && (add_valid_i != tag_out_valid)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Tag pipe: requester ID travels alongside its add, bubbles on idle cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_valid_q <= '0;
            for (int s = 0; s < ADD_LATENCY; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            tag_valid_q[0] <= issue;
            tag_id_q[0]    <= grant_idx;
            for (int s = 1; s < ADD_LATENCY; s++) begin
                tag_valid_q[s] <= tag_valid_q[s-1];
                tag_id_q[s]    <= tag_id_q[s-1];
            end
        end
    end

    // FIFO storage write (no reset; validity is tracked by the pointers)
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    // FIFO pointers and registered response head
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_q + PW'(push);
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_valid_q <= head_valid_d;
            res_id_q    <= head_entry_d[ENTRY_W-1:32];
            res_data_q  <= head_entry_d[31:0];
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_id_o    = res_id_q;
    assign res_data_o  = res_data_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Testbench for fp_add_arbiter: a stand-in fp_add pipeline, a scoreboard
// monitor built from the round-robin / credit / in-order rules, and one
// task per scenario with its own inline checks.
module tb_fp_add_arbiter;

    localparam int N   = 2;
    localparam int L   = 3;
    localparam int D   = 4;
    localparam int IDW = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic           add_valid;
    logic [31:0]    add_a;
    logic [31:0]    add_b;
    logic           add_valid_in;
    logic [31:0]    add_result;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic [IDW-1:0] res_id;
    logic [31:0]    res_data;
    logic           err;
    logic           inj_valid = 1'b0;
    logic           mon_err_en = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    fp_add_arbiter #(.NUM_REQ(N), .ADD_LATENCY(L), .RESULT_DEPTH(D)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .add_valid_o  (add_valid),
        .add_a_o      (add_a),
        .add_b_o      (add_b),
        .add_valid_i  (add_valid_in),
        .add_result_i (add_result),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_id_o     (res_id),
        .res_data_o   (res_data),
        .err_o        (err)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Stand-in adder: NaNs are quietened, 1.0+2.0 gives 3.0, otherwise a mix.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return a | 32'h0040_0000;
        if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return b | 32'h0040_0000;
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    // Fixed-latency adder pipeline (not reset, like a real datapath)
    logic [L-1:0] pv = '0;
    logic [31:0]  pr [L] = '{default: 32'd0};
    always @(posedge clk) begin
        pv    <= {pv[L-2:0], add_valid};
        pr[0] <= fp_model(add_a, add_b);
        for (int s = 1; s < L; s++) pr[s] <= pr[s-1];
    end
    assign add_valid_in = pv[L-1] | inj_valid;
    assign add_result   = pr[L-1];

    // Scoreboard: expected responses in issue order with earliest visible cycle
    typedef struct {
        int          id;
        logic [31:0] data;
        int          avail;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    int outstanding = 0;
    int last_g      = N - 1;
    int m_id;
    logic m_issue;
    logic m_rv;
    logic [N-1:0] m_ready;
    logic [N-1:0] rv;
    logic [31:0] ea;
    logic [31:0] eb;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            outstanding = 0;
            last_g = N - 1;
        end else begin
            m_issue = 1'b0;
            m_id = 0;
            if (outstanding < D) begin
                for (int k = 1; k <= N; k++) begin
                    rv = req_valid >> ((last_g + k) % N);
                    if (!m_issue && rv[0]) begin
                        m_issue = 1'b1;
                        m_id = (last_g + k) % N;
                    end
                end
            end
            m_ready = m_issue ? (N'(1) << m_id) : '0;
            ea = 32'(req_a >> (m_id * 32));
            eb = 32'(req_b >> (m_id * 32));
            checks++;
            if (req_ready !== m_ready) begin
                failures++;
                $display("FAIL mon_ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_ready);
            end
            checks++;
            if (add_valid !== m_issue) begin
                failures++;
                $display("FAIL mon_add_valid cyc=%0d got=%b exp=%b", cyc, add_valid, m_issue);
            end
            checks++;
            if ({add_a, add_b} !== (m_issue ? {ea, eb} : 64'd0)) begin
                failures++;
                $display("FAIL mon_operands cyc=%0d got=%h/%h exp=%h/%h", cyc, add_a, add_b,
                         m_issue ? ea : 32'd0, m_issue ? eb : 32'd0);
            end
            m_rv = 1'b0;
            if (exp_q.size() != 0) begin
                if (exp_q[0].avail <= cyc) m_rv = 1'b1;
            end
            checks++;
            if (res_valid !== m_rv) begin
                failures++;
                $display("FAIL mon_res_valid cyc=%0d got=%b exp=%b", cyc, res_valid, m_rv);
            end
            if (m_rv) begin
                checks++;
                if (res_id !== IDW'(exp_q[0].id) || res_data !== exp_q[0].data) begin
                    failures++;
                    $display("FAIL mon_response cyc=%0d got id=%0d data=%h exp id=%0d data=%h",
                             cyc, res_id, res_data, exp_q[0].id, exp_q[0].data);
                end
                if (res_ready) begin
                    void'(exp_q.pop_front());
                    outstanding--;
                end
            end
            if (mon_err_en) begin
                checks++;
                if (err !== 1'b0) begin
                    failures++;
                    $display("FAIL mon_err cyc=%0d got=%b exp=0", cyc, err);
                end
            end
            if (m_issue) begin
                e.id = m_id;
                e.data = fp_model(ea, eb);
                e.avail = cyc + L + 1;
                exp_q.push_back(e);
                outstanding++;
                last_g = m_id;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        tick();
        rst = 1'b1;
        req_valid = '0;
        inj_valid = 1'b0;
        repeat (n - 1) tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        tick();
        req_valid = '0;
        res_ready = 1'b1;
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || add_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_issue got ready=%b add_valid=%b exp 00/0", req_ready, add_valid);
        end
        tick();
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || res_id !== '0 || res_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_response got v=%b id=%0d data=%h exp 0/0/0", res_valid, res_id, res_data);
        end
        checks++;
        if (err !== 1'b0 || add_valid !== 1'b0 || add_a !== 32'd0 || add_b !== 32'd0) begin
            failures++;
            $display("FAIL reset_misc got err=%b add_valid=%b a=%h b=%h exp all 0", err, add_valid, add_a, add_b);
        end
    endtask

    task automatic test_single();
        tick();
        res_ready = 1'b1;
        req_valid = 2'b01;
        req_a[31:0] = 32'h3F80_0000;
        req_b[31:0] = 32'h4000_0000;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01 || add_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_grant got ready=%b add_valid=%b exp 01/1", req_ready, add_valid);
        end
        checks++;
        if (add_a !== 32'h3F80_0000 || add_b !== 32'h4000_0000) begin
            failures++;
            $display("FAIL single_operands got %h/%h exp 3f800000/40000000", add_a, add_b);
        end
        for (int k = 1; k <= L + 1; k++) begin
            tick();
            if (k == 1) req_valid = '0;
            @(negedge clk);
            if (k == L) begin
                checks++;
                if (res_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL single_early got res_valid=%b exp 0", res_valid);
                end
            end
            if (k == L + 1) begin
                checks++;
                if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== 32'h4040_0000) begin
                    failures++;
                    $display("FAIL single_result got v=%b id=%0d data=%h exp 1/0/40400000",
                             res_valid, res_id, res_data);
                end
            end
        end
        drain();
    endtask

    task automatic test_alternate();
        int issues;
        int pops;
        issues = 0;
        pops = 0;
        apply_reset(1);
        for (int c = 0; c < 24; c++) begin
            tick();
            res_ready = 1'b1;
            req_valid = 2'b11;
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            @(negedge clk);
            if (add_valid) begin
                checks++;
                if (req_ready !== ((issues % 2 == 0) ? 2'b01 : 2'b10)) begin
                    failures++;
                    $display("FAIL alt_grant issue=%0d got=%b exp=%b", issues, req_ready,
                             (issues % 2 == 0) ? 2'b01 : 2'b10);
                end
                issues++;
            end
            if (res_valid && res_ready) begin
                checks++;
                if (res_id !== IDW'(pops % 2)) begin
                    failures++;
                    $display("FAIL alt_resp_id pop=%0d got=%0d exp=%0d", pops, res_id, pops % 2);
                end
                pops++;
            end
        end
        checks++;
        if (issues != 20 || pops != 16) begin
            failures++;
            $display("FAIL alt_throughput got issues=%0d pops=%0d exp 20/16", issues, pops);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int issues;
        issues = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            res_ready = 1'b0;
            req_valid = 2'b10;
            req_a[63:32] = $urandom;
            req_b[63:32] = $urandom;
            @(negedge clk);
            if (req_ready == 2'b10) issues++;
        end
        checks++;
        if (issues != D || res_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_issues got issues=%0d res_valid=%b exp %0d/1", issues, res_valid, D);
        end
        tick();
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL bp_pop_cycle got ready=%b exp 00", req_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL bp_resume got ready=%b exp 10", req_ready);
        end
        drain();
    endtask

    task automatic test_special();
        logic [31:0] ca [3];
        logic [31:0] cb [3];
        logic [31:0] ce [3];
        bit seen;
        ca = '{32'h7FC0_0000, 32'h0000_0001, 32'h3F80_0000};
        cb = '{32'h3F80_0000, 32'h0000_0000, 32'hFF80_0001};
        ce = '{32'h7FC0_0000, 32'h0000_0001, 32'hFFC0_0001};
        for (int i = 0; i < 3; i++) begin
            tick();
            res_ready = 1'b1;
            req_valid = 2'b01;
            req_a[31:0] = ca[i];
            req_b[31:0] = cb[i];
            tick();
            req_valid = '0;
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                if (res_valid) begin
                    seen = 1'b1;
                    checks++;
                    if (res_data !== ce[i] || res_id !== 1'b0) begin
                        failures++;
                        $display("FAIL special_%0d got id=%0d data=%h exp 0/%h", i, res_id, res_data, ce[i]);
                    end
                end else begin
                    tick();
                end
            end
            if (!seen) begin
                checks++;
                failures++;
                $display("FAIL special_%0d_timeout got no response exp %h", i, ce[i]);
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            tick();
            req_valid = N'($urandom_range(0, 3));
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            res_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            checks++;
            if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
                failures++;
                $display("FAIL rand_onehot cyc=%0d got ready=%b valid=%b", cyc, req_ready, req_valid);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            tick();
            res_ready = 1'b1;
            req_valid = 2'b11;
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if (add_valid !== 1'b1) begin
                failures++;
                $display("FAIL mid_issue c=%0d got add_valid=%b exp 1", c, add_valid);
            end
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || add_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_in_reset got ready=%b add_valid=%b exp 00/0", req_ready, add_valid);
        end
        tick();
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || res_id !== '0 || res_data !== 32'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL mid_after_reset got v=%b id=%0d data=%h err=%b exp all 0",
                     res_valid, res_id, res_data, err);
        end
        for (int k = 0; k < L + 3; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL mid_discard k=%0d got v=%b err=%b exp 0/0", k, res_valid, err);
            end
        end
        tick();
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL mid_first_grant got=%b exp 01", req_ready);
        end
        drain();
    endtask

    task automatic test_error();
        repeat (L + 2) tick();
        mon_err_en = 1'b0;
        tick();
        inj_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_early got=%b exp 0", err);
        end
        tick();
        inj_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_set got=%b exp 1", err);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (err !== 1'b1) begin
                failures++;
                $display("FAIL err_sticky k=%0d got=%b exp 1", k, err);
            end
        end
        apply_reset(1);
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_cleared got=%b exp 0", err);
        end
        mon_err_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog sim did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_special();
        test_random();
        test_reset_mid();
        test_error();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
